// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the rr_arb_mux2_4b arbiter slice.
//   arb_state_t : ARB (free to arbitrate) / LOCK (grant held for a packet)
//   NBITS       : message width, fixed at 4 by the Mux2_4b datapath
//   SRC_IN0/1   : requester indices, also used as the mux select value
//   rr_pick()   : round-robin choice between two requesters, no lock state
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int   NBITS   = 4;
    localparam logic SRC_IN0 = 1'b0;
    localparam logic SRC_IN1 = 1'b1;

    // With both requesters valid the preferred one (prio) wins; otherwise the
    // single valid requester wins. With neither valid the result is don't-care
    // because the caller qualifies the grant with the valid bits.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic prio);
        if (v0 && v1) begin
            return prio;
        end else if (v1) begin
            return SRC_IN1;
        end else begin
            return SRC_IN0;
        end
    endfunction

endpackage

// File: rtl/Mux2_4b.sv
// -----------------------------------------------------------------------------
// Mux2_4b
// Two-input, 4-bit combinational multiplexer used as the shared datapath.
// Ports:
//   i_in0 [3:0] : selected when i_sel = 0
//   i_in1 [3:0] : selected when i_sel = 1
//   i_sel       : select
//   o_out [3:0] : selected data
// -----------------------------------------------------------------------------
module Mux2_4b
    import arb_pkg::*;
(
    input  logic [NBITS-1:0] i_in0,
    input  logic [NBITS-1:0] i_in1,
    input  logic             i_sel,
    output logic [NBITS-1:0] o_out
);

    assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/rr_arb_mux2_4b.sv
// -----------------------------------------------------------------------------
// rr_arb_mux2_4b
// Round-robin arbiter sharing one Mux2_4b datapath between two val/rdy
// requesters. Multi-beat packets hold the grant until their last beat is
// accepted. Accepted beats land in a single-entry output register.
// Ports:
//   clk, reset_n                  : rising-edge clock, async active-low reset
//   in0_val/rdy/msg[3:0]/last     : requester 0 beat channel
//   in1_val/rdy/msg[3:0]/last     : requester 1 beat channel
//   out_val/rdy/msg[3:0]/last     : registered downstream beat channel
//   out_src                       : requester that produced the output beat
// -----------------------------------------------------------------------------
module rr_arb_mux2_4b
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,

    input  logic             in0_val,
    output logic             in0_rdy,
    input  logic [NBITS-1:0] in0_msg,
    input  logic             in0_last,

    input  logic             in1_val,
    output logic             in1_rdy,
    input  logic [NBITS-1:0] in1_msg,
    input  logic             in1_last,

    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_msg,
    output logic             out_last,
    output logic             out_src
);

    arb_state_t       r_state;
    logic             r_prio;   // preferred requester while in ARB
    logic             r_owner;  // grant holder while in LOCK

    logic             w_can_acc;
    logic             w_gnt_vld;
    logic             w_gnt_idx;
    logic             w_xfer;
    logic             w_last;
    logic [NBITS-1:0] w_msg;

    // The output register can take a new beat when empty or when its current
    // beat drains on this same edge, giving one beat per cycle.
    assign w_can_acc = !out_val || out_rdy;

    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = SRC_IN0;
        if (r_state == LOCK) begin
            // The owner keeps the grant even while its val is low, so the
            // other requester stalls through any bubble inside the packet.
            w_gnt_vld = 1'b1;
            w_gnt_idx = r_owner;
        end else begin
            w_gnt_vld = in0_val || in1_val;
            w_gnt_idx = rr_pick(in0_val, in1_val, r_prio);
        end
    end

    // reset_n gates the ready outputs so nothing is accepted while in reset.
    assign in0_rdy = reset_n && w_gnt_vld && (w_gnt_idx == SRC_IN0) && w_can_acc && in0_val;
    assign in1_rdy = reset_n && w_gnt_vld && (w_gnt_idx == SRC_IN1) && w_can_acc && in1_val;
    assign w_xfer  = in0_rdy || in1_rdy;

    Mux2_4b u_mux (
        .i_in0 (in0_msg),
        .i_in1 (in1_msg),
        .i_sel (w_gnt_idx),
        .o_out (w_msg)
    );

    assign w_last = (w_gnt_idx == SRC_IN1) ? in1_last : in0_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ARB;
            r_prio   <= SRC_IN0;
            r_owner  <= SRC_IN0;
            out_val  <= 1'b0;
            out_msg  <= '0;
            out_last <= 1'b0;
            out_src  <= SRC_IN0;
        end else begin
            if (w_xfer) begin
                // A load takes priority over a drain: together they replace
                // the buffered beat with no bubble.
                out_val  <= 1'b1;
                out_msg  <= w_msg;
                out_last <= w_last;
                out_src  <= w_gnt_idx;
                if (w_last) begin
                    r_state <= ARB;
                    r_prio  <= ~w_gnt_idx;
                end else begin
                    r_state <= LOCK;
                    r_owner <= w_gnt_idx;
                end
            end else if (out_val && out_rdy) begin
                out_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux2_4b.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux2_4b
// Directed bench for rr_arb_mux2_4b. The stimulus pushes each expected output
// beat into a queue when it drives the accepting cycle; an independent monitor
// pops and compares whenever the DUT hands a beat downstream.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux2_4b;
    import arb_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in0_val = 1'b0, in0_rdy, in0_last = 1'b0;
    logic [NBITS-1:0] in0_msg = '0;
    logic             in1_val = 1'b0, in1_rdy, in1_last = 1'b0;
    logic [NBITS-1:0] in1_msg = '0;
    logic             out_val, out_rdy = 1'b0, out_last, out_src;
    logic [NBITS-1:0] out_msg;

    typedef struct packed {
        logic [NBITS-1:0] msg;
        logic             last;
        logic             src;
    } beat_t;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux2_4b dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in0_val  (in0_val),
        .in0_rdy  (in0_rdy),
        .in0_msg  (in0_msg),
        .in0_last (in0_last),
        .in1_val  (in1_val),
        .in1_rdy  (in1_rdy),
        .in1_msg  (in1_msg),
        .in1_last (in1_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .out_last (out_last),
        .out_src  (out_src)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [NBITS-1:0] m, input logic l, input logic s);
        sb_q.push_back(beat_t'({m, l, s}));
    endtask

    // Drive just after the rising edge; sample on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic check_rdy(input string name, input logic [1:0] exp);
        check(name, 32'({in1_rdy, in0_rdy}), 32'(exp));
    endtask

    // Scoreboard monitor: a beat leaves the DUT when out_val && out_rdy.
    always @(negedge clk) begin
        beat_t e;
        if (reset_n && out_val && out_rdy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_msg",  32'(out_msg),  32'(e.msg));
                check("sb_last", 32'(out_last), 32'(e.last));
                check("sb_src",  32'(out_src),  32'(e.src));
            end
        end
    end

    initial begin
        // ---- reset: ready forced low even with a request pending ----
        in0_val = 1'b1;
        out_rdy = 1'b1;
        #12;
        check("rst_in0_rdy", 32'(in0_rdy), 32'd0);
        check("rst_out_val", 32'(out_val), 32'd0);
        next();
        reset_n = 1'b1;
        in0_val = 1'b0;
        next();
        to_neg();
        check("idle_out_val",  32'(out_val),  32'd0);
        check("idle_out_msg",  32'(out_msg),  32'd0);
        check("idle_out_last", 32'(out_last), 32'd0);
        check("idle_out_src",  32'(out_src),  32'd0);
        check_rdy("idle_rdy", 2'b00);

        // ---- single requester ----
        next();
        in0_val = 1'b1; in0_msg = 4'h3; in0_last = 1'b1;
        push(4'h3, 1'b1, SRC_IN0);
        to_neg();
        check_rdy("single_rdy", 2'b01);
        next();
        in0_val = 1'b0;
        to_neg();
        check("single_out_val", 32'(out_val), 32'd1);
        check("single_out_msg", 32'(out_msg), 32'h3);

        // ---- reset mid-packet discards lock and buffered beat ----
        next();
        out_rdy = 1'b0;
        in0_val = 1'b1; in0_msg = 4'h1; in0_last = 1'b0;
        to_neg();
        check_rdy("midrst_first_rdy", 2'b01);
        next();
        in0_msg = 4'h2;
        to_neg();
        check("midrst_buffered", 32'(out_val), 32'd1);
        check_rdy("midrst_bp_rdy", 2'b00);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_out_val", 32'(out_val), 32'd0);
        check_rdy("midrst_rdy", 2'b00);
        next();
        reset_n = 1'b1;
        in0_val = 1'b0;
        out_rdy = 1'b1;
        to_neg();
        check("midrst_after_val", 32'(out_val), 32'd0);

        // ---- round-robin, single-beat packets: 0,1,0,1 ----
        next();
        in0_val = 1'b1; in0_msg = 4'hA; in0_last = 1'b1;
        in1_val = 1'b1; in1_msg = 4'h5; in1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                push(4'hA, 1'b1, SRC_IN0);
                to_neg();
                check_rdy("rr_rdy0", 2'b01);
            end else begin
                push(4'h5, 1'b1, SRC_IN1);
                to_neg();
                check_rdy("rr_rdy1", 2'b10);
            end
            next();
        end

        // ---- packet lock: in0 three beats while in1 waits ----
        in1_msg = 4'h9; in1_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in0_msg  = 4'(i + 1);
            in0_last = (i == 2);
            push(4'(i + 1), (i == 2), SRC_IN0);
            to_neg();
            check_rdy("lock_rdy", 2'b01);
            next();
        end
        in0_val = 1'b0;
        push(4'h9, 1'b1, SRC_IN1);
        to_neg();
        check_rdy("lock_release_rdy", 2'b10);
        next();

        // ---- lock with a two-cycle bubble ----
        in0_val = 1'b1; in0_msg = 4'h4; in0_last = 1'b0;
        in1_msg = 4'h6; in1_last = 1'b1;
        push(4'h4, 1'b0, SRC_IN0);
        to_neg();
        check_rdy("bubble_first_rdy", 2'b01);
        next();
        in0_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            check_rdy("bubble_hold_rdy", 2'b00);
            next();
        end
        in0_val = 1'b1; in0_msg = 4'h5; in0_last = 1'b1;
        push(4'h5, 1'b1, SRC_IN0);
        to_neg();
        check_rdy("bubble_last_rdy", 2'b01);
        next();
        in0_val = 1'b0;
        push(4'h6, 1'b1, SRC_IN1);
        to_neg();
        check_rdy("bubble_in1_rdy", 2'b10);
        next();

        // ---- backpressure with 0x7 buffered; prio must stay on in1 ----
        in1_val = 1'b0;
        in0_val = 1'b1; in0_msg = 4'h7; in0_last = 1'b1;
        push(4'h7, 1'b1, SRC_IN0);
        to_neg();
        check_rdy("bp_load_rdy", 2'b01);
        next();
        out_rdy = 1'b0;
        in0_msg = 4'h8;
        in1_val = 1'b1; in1_msg = 4'hB; in1_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            check("bp_out_val", 32'(out_val), 32'd1);
            check("bp_out_msg", 32'(out_msg), 32'h7);
            check_rdy("bp_rdy", 2'b00);
            next();
        end
        out_rdy = 1'b1;
        push(4'hB, 1'b1, SRC_IN1);
        to_neg();
        check_rdy("bp_release_rdy", 2'b10);
        next();
        in1_val = 1'b0;
        push(4'h8, 1'b1, SRC_IN0);
        to_neg();
        check("bp_nogap_val", 32'(out_val), 32'd1);
        check("bp_nogap_msg", 32'(out_msg), 32'hB);
        check_rdy("bp_after_rdy", 2'b01);
        next();
        in0_val = 1'b0;

        // ---- drain remaining expected beats, bounded ----
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            next();
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux2_4b.md
Name: rr_arb_mux2_4b

Overview:
- Round-robin arbiter and sequencer that shares one Mux2_4b datapath between two 4-bit val/rdy requesters.
- Supports multi-beat packets: the grant is locked to one requester until its last beat is accepted.
- Muxed beats go into a single-entry output register, so the downstream interface is fully registered.
- Sits between two message producers and one shared 4-bit consumer channel.

Parameters:
- NBITS, 4, message width. Fixed at 4 to match the Mux2_4b datapath; other values are unsupported.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in0_val  input  1  requester 0 beat valid.
- in0_rdy  output  1  requester 0 beat accepted this cycle when high together with in0_val.
- in0_msg  input  4  requester 0 data.
- in0_last  input  1  final beat of the requester 0 packet.
- in1_val, in1_rdy, in1_msg, in1_last: same as requester 0, for requester 1.
- out_val  output  1  output register holds a beat.
- out_rdy  input  1  downstream accepts a beat.
- out_msg  output  4  registered beat data.
- out_last  output  1  registered last flag.
- out_src  output  1  requester that sourced the beat (0 or 1).

Behaviour:
- Reset: reset_n low asynchronously clears the following, and all are low/zero in the first cycle after release:
  - out_val=0, out_msg=0, out_last=0, out_src=0.
  - state=ARB, prio=0 (requester 0 preferred).
  - in0_rdy and in1_rdy are forced to 0 while reset_n is low.
- Reset mid-packet discards the lock and any buffered beat. No beat is emitted after reset until a new request arrives.
- Handshake: a transfer happens when val&&rdy on a cycle edge. Upstream must hold msg/last stable while val is high and rdy is low. Upstream must not drop val before the transfer.
- Buffer accept: can_acc = !out_val || out_rdy. This gives full throughput, and out_rdy→inX_rdy is a permitted combinational path.
- Grant (combinational):
  - ARB, only one val high → grant that requester.
  - ARB, both val high → grant requester prio.
  - ARB, neither val high → no grant.
  - LOCK(o) → grant o only. The other requester's rdy=0 even while o has val low (bubble allowed).
- Ready: inX_rdy = (grant==X) && can_acc && inX_val.
- Datapath: the Mux2_4b sel input is driven by the grant index; it selects msg and last.
- Latency: a beat accepted at edge t appears on out_* from cycle t+1. Order is preserved, with no drop and no duplicate.
- Output register:
  - Load on transfer: out_val=1, msg/last/src loaded.
  - Else if out_val && out_rdy: out_val=0. msg/last/src hold their last value.
- State transitions on a transfer from requester w:
  - ARB, last=0 → LOCK(w).
  - ARB, last=1 → stay ARB, prio=!w.
  - LOCK(w), last=0 → stay LOCK(w).
  - LOCK(w), last=1 → ARB, prio=!w.
- No transfer → state and prio are unchanged, including while out_rdy is held low (backpressure). Grant stays stable under backpressure because prio only updates on a transfer.
- Fairness: with both requesters continuously valid and single-beat packets, grants alternate 0,1,0,1...
- Simultaneous events: a drain and a load in the same cycle replace the buffered beat with no gap.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {ARB, LOCK} arb_state_t.
  - localparam NBITS=4.
  - localparam SRC_IN0=1'b0, SRC_IN1=1'b1.
- One sub-module instance: Mux2_4b for msg. The last bit is muxed inline.
- Grant, state and prio logic live in the top module.

Test Plan:
- Reset then idle: after reset_n rises, out_val=0 and both rdy=0 with no val. Asserting reset_n low mid-packet clears out_val within the same cycle.
- Single requester: in0 sends msg 0x3 with last=1 and out_rdy=1 → in0_rdy=1. Next cycle out_val=1, out_msg=0x3, out_src=0, out_last=1.
- Round-robin: both val continuously, single-beat packets (in0 msg 0xA, in1 msg 0x5), out_rdy=1 → out_src sequence 0,1,0,1 and msgs 0xA,0x5,0xA,0x5, one beat per cycle.
- Packet lock: in0 sends 3 beats 0x1,0x2,0x3 (last on 0x3) with in1 val held high → in1_rdy=0 for all three beats. The output shows 0x1,0x2,0x3, then 0x9 from in1.
- Lock with bubble: in0 sends beat 0x4 (last=0), drops val for 2 cycles, then sends 0x5 (last=1), while in1 is valid throughout → no in1 transfer until after 0x5.
- Backpressure: out_rdy=0 for 3 cycles with beat 0x7 buffered and both val high → out_msg stays 0x7, both rdy=0, prio is unchanged. When out_rdy rises, the drain and the new load happen in the same cycle.
